// File: rtl/result_broadcast_arbiter.sv
// Per-source result FIFOs drained round-robin onto a single registered,
// valid-only operand-update broadcast bus (one result per cycle).
module result_broadcast_arbiter #(
  parameter int SOURCES     = 4,
  parameter int FIFO_DEPTH  = 2,
  parameter int RS_ID_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SOURCES-1:0]         src_valid,
  output logic [SOURCES-1:0]         src_ready,
  input  logic [RS_ID_WIDTH-1:0]     src_rs_id [SOURCES],
  input  logic [31:0]                src_value [SOURCES],
  output logic                       bcast_valid,
  output logic [RS_ID_WIDTH-1:0]     bcast_rs_id,
  output logic [31:0]                bcast_value,
  output logic [$clog2(SOURCES)-1:0] bcast_source
);

  localparam int SRC_W = $clog2(SOURCES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = RS_ID_WIDTH + 32;

  typedef logic [ENT_W-1:0] entry_t;

  entry_t             mem_r       [SOURCES][FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r    [SOURCES];
  logic [PTR_W-1:0]   rd_ptr_r    [SOURCES];
  logic [CNT_W-1:0]   count_r     [SOURCES];
  logic [CNT_W-1:0]   count_nxt_s [SOURCES];
  logic [SOURCES-1:0] ready_r;
  logic [SOURCES-1:0] push_s;
  logic [SOURCES-1:0] pop_s;
  logic [SRC_W-1:0]   last_grant_r;
  logic [SRC_W-1:0]   grant_idx_s;
  logic [SRC_W-1:0]   cand_idx_s;
  logic               grant_valid_s;
  entry_t             head_s;

  // Ready comes from the registered occupancy; reset forces it low immediately.
  assign src_ready = ready_r & {SOURCES{rst}};
  assign push_s    = src_valid & src_ready;

  // Round-robin search starting just after the last granted source.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = {SRC_W{1'b0}};
    cand_idx_s    = {SRC_W{1'b0}};
    for (int i = 1; i <= SOURCES; i++) begin
      cand_idx_s = SRC_W'((int'(last_grant_r) + i) % SOURCES);
      if (!grant_valid_s && (count_r[cand_idx_s] != {CNT_W{1'b0}})) begin
        grant_valid_s = 1'b1;
        grant_idx_s   = cand_idx_s;
      end else begin
        grant_valid_s = grant_valid_s;
      end
    end
  end

  // Pop decode, granted head and next occupancy per FIFO.
  always_comb begin
    pop_s  = {SOURCES{1'b0}};
    head_s = mem_r[grant_idx_s][rd_ptr_r[grant_idx_s]];
    if (grant_valid_s) begin
      pop_s[grant_idx_s] = 1'b1;
    end else begin
      pop_s = {SOURCES{1'b0}};
    end
    for (int s = 0; s < SOURCES; s++) begin
      count_nxt_s[s] = count_r[s] + CNT_W'(push_s[s]) - CNT_W'(pop_s[s]);
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    for (int s = 0; s < SOURCES; s++) begin
      if (push_s[s]) begin
        mem_r[s][wr_ptr_r[s]] <= {src_rs_id[s], src_value[s]};
      end
    end
  end

  // Pointers, counts, arbiter state and broadcast registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SOURCES; s++) begin
        wr_ptr_r[s] <= {PTR_W{1'b0}};
        rd_ptr_r[s] <= {PTR_W{1'b0}};
        count_r[s]  <= {CNT_W{1'b0}};
      end
      ready_r      <= {SOURCES{1'b0}};
      last_grant_r <= SRC_W'(SOURCES - 1);
      bcast_valid  <= 1'b0;
      bcast_rs_id  <= {RS_ID_WIDTH{1'b0}};
      bcast_value  <= 32'h0000_0000;
      bcast_source <= {SRC_W{1'b0}};
    end else begin
      for (int s = 0; s < SOURCES; s++) begin
        if (push_s[s]) wr_ptr_r[s] <= wr_ptr_r[s] + PTR_W'(1);
        if (pop_s[s])  rd_ptr_r[s] <= rd_ptr_r[s] + PTR_W'(1);
        count_r[s] <= count_nxt_s[s];
        ready_r[s] <= (count_nxt_s[s] < CNT_W'(FIFO_DEPTH));
      end
      if (grant_valid_s) last_grant_r <= grant_idx_s;
      bcast_valid  <= grant_valid_s;
      bcast_rs_id  <= grant_valid_s ? head_s[ENT_W-1:32] : {RS_ID_WIDTH{1'b0}};
      bcast_value  <= grant_valid_s ? head_s[31:0] : 32'h0000_0000;
      bcast_source <= grant_valid_s ? grant_idx_s : {SRC_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_result_broadcast_arbiter.sv
// Self-checking bench for result_broadcast_arbiter against a queue-based
// reference model of per-source FIFOs and round-robin broadcast.
module tb_result_broadcast_arbiter;

  localparam int S  = 4;
  localparam int D  = 2;
  localparam int W  = 5;
  localparam int SW = $clog2(S);

  logic          clk = 1'b0;
  logic          rst;
  logic [S-1:0]  src_valid;
  logic [S-1:0]  src_ready;
  logic [W-1:0]  src_rs_id [S];
  logic [31:0]   src_value [S];
  logic          bcast_valid;
  logic [W-1:0]  bcast_rs_id;
  logic [31:0]   bcast_value;
  logic [SW-1:0] bcast_source;

  result_broadcast_arbiter #(.SOURCES(S), .FIFO_DEPTH(D), .RS_ID_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_ready(src_ready),
    .src_rs_id(src_rs_id), .src_value(src_value), .bcast_valid(bcast_valid),
    .bcast_rs_id(bcast_rs_id), .bcast_value(bcast_value), .bcast_source(bcast_source)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] id;
    logic [31:0]  val;
  } ent_t;

  // Reference model: one queue per source, last granted index, expected bus.
  ent_t          mq [S][$];
  int            m_lg;
  logic [S-1:0]  m_rdy;
  logic          e_valid;
  logic [W-1:0]  e_id;
  logic [31:0]   e_val;
  logic [SW-1:0] e_src;

  task automatic tick();
    logic [S-1:0] hs;
    ent_t         h;
    int           c;
    if (!rst) begin
      for (int s = 0; s < S; s++) mq[s].delete();
      m_lg = S - 1; m_rdy = '0;
      e_valid = 1'b0; e_id = '0; e_val = '0; e_src = '0;
    end else begin
      hs = src_valid & m_rdy;
      e_valid = 1'b0; e_id = '0; e_val = '0; e_src = '0;
      for (int k = 1; k <= S; k++) begin
        c = (m_lg + k) % S;
        if (!e_valid && mq[c].size() > 0) begin
          h = mq[c].pop_front();
          e_valid = 1'b1; e_id = h.id; e_val = h.val; e_src = SW'(c); m_lg = c;
        end
      end
      for (int s = 0; s < S; s++)
        if (hs[s]) mq[s].push_back('{id: src_rs_id[s], val: src_value[s]});
      for (int s = 0; s < S; s++) m_rdy[s] = (mq[s].size() < D);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_data();
    for (int s = 0; s < S; s++) begin
      src_rs_id[s] = W'($urandom);
      src_value[s] = $urandom;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; src_valid = '1; randomize_data();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (src_ready !== 4'b0000 || {bcast_valid, bcast_rs_id, bcast_value, bcast_source} !== 40'd0) begin
        failures++;
        $display("FAIL reset_hold cycle=%0d ready=%b bus=%b/%0d/%h/%0d expected ready=0000 bus all zero",
                 c, src_ready, bcast_valid, bcast_rs_id, bcast_value, bcast_source);
      end
    end
    rst = 1'b1; src_valid = '0;
    tick();
    checks++;
    if (src_ready !== 4'b1111 || bcast_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release ready=%b valid=%b expected ready=1111 valid=0", src_ready, bcast_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0]  exp_id  [5] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd20};
    logic [SW-1:0] exp_src [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    src_valid = 4'b1111; randomize_data();
    for (int s = 0; s < S; s++) src_rs_id[s] = W'(10 + s);
    tick();
    src_valid = '0;
    checks++;
    if (bcast_valid !== 1'b0) begin
      failures++;
      $display("FAIL rr_first_cycle valid=%b expected 0", bcast_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      src_valid = (i == 0) ? 4'b0001 : 4'b0000;
      src_rs_id[0] = 5'd20;
      checks++;
      if (bcast_valid !== 1'b1 || bcast_rs_id !== exp_id[i] || bcast_source !== exp_src[i] ||
          bcast_value !== e_val) begin
        failures++;
        $display("FAIL rr_order slot=%0d got v=%b id=%0d src=%0d val=%h expected v=1 id=%0d src=%0d val=%h",
                 i, bcast_valid, bcast_rs_id, bcast_source, bcast_value, exp_id[i], exp_src[i], e_val);
      end
    end
    src_valid = '0;
  endtask

  task automatic test_single();
    logic [39:0] exp_bus [3] = '{40'd0, {1'b1, 5'd9, 32'hDEADBEEF, 2'd2}, 40'd0};
    repeat (2) tick();
    src_valid = 4'b0100; src_rs_id[2] = 5'd9; src_value[2] = 32'hDEADBEEF;
    checks++;
    if (src_ready[2] !== 1'b1) begin
      failures++;
      $display("FAIL single_ready got=%b expected 1", src_ready[2]);
    end
    tick();
    src_valid = '0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      checks++;
      if ({bcast_valid, bcast_rs_id, bcast_value, bcast_source} !== exp_bus[i]) begin
        failures++;
        $display("FAIL single_result t+%0d got %b/%0d/%h/%0d expected %h",
                 i + 1, bcast_valid, bcast_rs_id, bcast_value, bcast_source, exp_bus[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int          sent;
    logic        hs1;
    logic [31:0] got [$];
    src_valid = 4'b1000; randomize_data();
    tick();
    src_valid = '0;
    repeat (3) tick();
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      randomize_data();
      src_valid = {c < 10, c < 10, sent < 3, c < 10};
      src_value[1] = 32'(sent + 1);
      hs1 = src_valid[1] && m_rdy[1] && rst;
      tick();
      checks++;
      if ({bcast_valid, bcast_rs_id, bcast_value, bcast_source} !== {e_valid, e_id, e_val, e_src} ||
          src_ready !== (m_rdy & {S{rst}})) begin
        failures++;
        $display("FAIL backpressure_cycle c=%0d got %b/%0d/%h/%0d rdy=%b expected %b/%0d/%h/%0d rdy=%b",
                 c, bcast_valid, bcast_rs_id, bcast_value, bcast_source, src_ready,
                 e_valid, e_id, e_val, e_src, m_rdy & {S{rst}});
      end
      if (hs1) begin
        sent++;
        if (sent == 2) begin
          checks++;
          if (src_ready[1] !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_full ready1=%b expected 0", src_ready[1]);
          end
        end
      end
      if (bcast_valid && bcast_source == 2'd1) got.push_back(bcast_value);
    end
    src_valid = '0;
    checks++;
    if (got.size() != 3 || got[0] !== 32'd1 || got[1] !== 32'd2 || got[2] !== 32'd3) begin
      failures++;
      $display("FAIL backpressure_order got count=%0d expected 3 values 1,2,3", got.size());
    end
  endtask

  task automatic test_fairness();
    int gcount [S];
    int last   [S];
    int maxgap;
    repeat (6) tick();
    for (int s = 0; s < S; s++) begin gcount[s] = 0; last[s] = -1; end
    maxgap = 0;
    for (int c = 0; c < 40; c++) begin
      src_valid = '1; randomize_data();
      tick();
      checks++;
      if ({bcast_valid, bcast_rs_id, bcast_value, bcast_source} !== {e_valid, e_id, e_val, e_src}) begin
        failures++;
        $display("FAIL fairness_cycle c=%0d got %b/%0d/%h/%0d expected %b/%0d/%h/%0d",
                 c, bcast_valid, bcast_rs_id, bcast_value, bcast_source, e_valid, e_id, e_val, e_src);
      end
      if (bcast_valid) begin
        gcount[bcast_source]++;
        if (last[bcast_source] >= 0 && c - last[bcast_source] > maxgap) maxgap = c - last[bcast_source];
        last[bcast_source] = c;
      end
    end
    src_valid = '0;
    for (int s = 0; s < S; s++) begin
      checks++;
      if (gcount[s] < 9 || gcount[s] > 11) begin
        failures++;
        $display("FAIL fairness_count src=%0d got=%0d expected 10+-1", s, gcount[s]);
      end
    end
    checks++;
    if (maxgap > S || maxgap == 0) begin
      failures++;
      $display("FAIL fairness_gap got=%0d expected 1..%0d", maxgap, S);
    end
    repeat (10) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      src_valid = S'($urandom); randomize_data();
      tick();
      checks++;
      if ({bcast_valid, bcast_rs_id, bcast_value, bcast_source} !== {e_valid, e_id, e_val, e_src} ||
          src_ready !== (m_rdy & {S{rst}})) begin
        failures++;
        $display("FAIL random_cycle c=%0d got %b/%0d/%h/%0d rdy=%b expected %b/%0d/%h/%0d rdy=%b",
                 c, bcast_valid, bcast_rs_id, bcast_value, bcast_source, src_ready,
                 e_valid, e_id, e_val, e_src, m_rdy & {S{rst}});
      end
    end
    src_valid = '0;
  endtask

  task automatic test_mid_reset();
    int  nvalid;
    logic first_seen;
    src_valid = '1;
    repeat (4) begin randomize_data(); tick(); end
    rst = 1'b0;
    tick();
    checks++;
    if (src_ready !== 4'b0000 || {bcast_valid, bcast_rs_id, bcast_value, bcast_source} !== 40'd0) begin
      failures++;
      $display("FAIL midreset_hold ready=%b bus=%b/%0d/%h/%0d expected ready=0000 bus zero",
               src_ready, bcast_valid, bcast_rs_id, bcast_value, bcast_source);
    end
    rst = 1'b1; src_valid = '0;
    tick();
    checks++;
    if (src_ready !== 4'b1111 || bcast_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_release ready=%b valid=%b expected 1111/0", src_ready, bcast_valid);
    end
    src_valid = '1;
    for (int s = 0; s < S; s++) begin
      src_rs_id[s] = W'(16 + s); src_value[s] = 32'hC0DE_0000 + 32'(s);
    end
    tick();
    src_valid = '0;
    nvalid = 0; first_seen = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (bcast_valid) begin
        nvalid++;
        checks++;
        if (bcast_value[31:16] !== 16'hC0DE || (!first_seen && (bcast_source !== 2'd0 ||
            bcast_value !== 32'hC0DE_0000))) begin
          failures++;
          $display("FAIL midreset_broadcast c=%0d src=%0d val=%h expected fresh result, first from source 0",
                   c, bcast_source, bcast_value);
        end
        first_seen = 1'b1;
      end
    end
    checks++;
    if (nvalid != 4) begin
      failures++;
      $display("FAIL midreset_count got=%0d expected 4", nvalid);
    end
  endtask

  initial begin
    rst = 1'b0; src_valid = '0;
    for (int s = 0; s < S; s++) begin src_rs_id[s] = '0; src_value[s] = '0; end
    m_lg = S - 1; m_rdy = '0;
    e_valid = 1'b0; e_id = '0; e_val = '0; e_src = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_fairness();
    test_random();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
